// File: rtl/sqrt_datapath.sv
// ---------------------------------------------------------------------------
// sqrt_datapath
//   Non-restoring integer square-root datapath, one radicand bit-pair per step.
//   An external control FSM sequences the iterations through counter_EN/OP_EN
//   and requests the final correction/result latch through OP_READY.
//
// Parameters
//   WIDTH              radicand width in bits (even, >= 4)
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous active-low reset
//   start              capture radicand, clear working state (overrides all)
//   radicand           unsigned operand, sampled when start=1
//   counter_EN, OP_EN  both high (with start low) perform one iteration
//   OP_READY           latch the corrected result once iterations are done
//   COUNTER_FLAG       all WIDTH/2 iterations done
//   MUX_FLAG           partial remainder negative (next op adds)
//   ADDR_OR_REST_FLAG  partial remainder non-negative (next op subtracts)
//   MUX_FLAG2          final correction required
//   root               integer square root
//   remainder          radicand - root*root
//   result_valid       root/remainder hold a completed result
//   done               one-cycle pulse when a result is latched
// ---------------------------------------------------------------------------
module sqrt_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    input  logic               counter_EN,
    input  logic               OP_EN,
    input  logic               OP_READY,
    output logic               COUNTER_FLAG,
    output logic               MUX_FLAG,
    output logic               ADDR_OR_REST_FLAG,
    output logic               MUX_FLAG2,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   remainder,
    output logic               result_valid,
    output logic               done
);

    localparam int unsigned HW = WIDTH / 2;     // root width
    localparam int unsigned RW = HW + 2;        // signed partial remainder width
    localparam int unsigned PW = RW + 2;        // shifted remainder before truncation
    localparam int unsigned KW = $clog2(HW + 1); // iteration counter width

    logic [WIDTH-1:0]     d_q,     d_d;
    logic signed [RW-1:0] r_q,     r_d;
    logic [HW-1:0]        q_q,     q_d;
    logic [KW-1:0]        k_q,     k_d;
    logic [HW-1:0]        root_q,  root_d;
    logic [HW:0]          rem_q,   rem_d;
    logic                 valid_q, valid_d;
    logic                 done_q,  done_d;

    logic                 counter_flag_c;
    logic                 r_neg_c;
    logic                 step_en_c;
    logic                 latch_en_c;
    logic signed [PW-1:0] p_c;
    logic signed [PW-1:0] q_term_c;
    logic signed [PW-1:0] r_wide_c;
    logic signed [RW-1:0] r_new_c;
    logic [HW-1:0]        q_new_c;
    logic signed [RW-1:0] r_fix_c;

    // Status flags derived directly from registered state
    always_comb begin
        counter_flag_c = (k_q == KW'(HW));
        r_neg_c        = r_q[RW-1];
    end

    assign COUNTER_FLAG      = counter_flag_c;
    assign MUX_FLAG          = r_neg_c;
    assign ADDR_OR_REST_FLAG = ~r_neg_c;
    assign MUX_FLAG2         = counter_flag_c & r_neg_c;

    // Qualifiers: start wins over everything; steps stop once k reaches HW
    always_comb begin
        step_en_c  = counter_EN & OP_EN & ~start & (k_q < KW'(HW));
        latch_en_c = OP_READY & counter_flag_c & ~valid_q & ~start;
    end

    // One non-restoring iteration
    always_comb begin
        // Concatenation is (R<<2) | next radicand bit-pair, sign preserved
        p_c = $signed({r_q, d_q[WIDTH-1:WIDTH-2]});
        if (r_neg_c) begin
            q_term_c = $signed({2'b00, q_q, 2'b11});
            r_wide_c = p_c + q_term_c;
        end else begin
            q_term_c = $signed({2'b00, q_q, 2'b01});
            r_wide_c = p_c - q_term_c;
        end
        // The true result always fits in RW bits; upper bits are sign copies
        r_new_c = r_wide_c[RW-1:0];
        q_new_c = {q_q[HW-2:0], ~r_new_c[RW-1]};
    end

    // Final correction: a negative remainder is restored by adding 2Q+1
    always_comb begin
        if (r_neg_c) begin
            r_fix_c = r_q + $signed({1'b0, q_q, 1'b1});
        end else begin
            r_fix_c = r_q;
        end
    end

    // Next-state for all registers
    always_comb begin
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        k_d     = k_q;
        root_d  = root_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (start) begin
            d_d     = radicand;
            r_d     = '0;
            q_d     = '0;
            k_d     = '0;
            valid_d = 1'b0;
        end else begin
            if (step_en_c) begin
                r_d = r_new_c;
                q_d = q_new_c;
                d_d = {d_q[WIDTH-3:0], 2'b00};
                k_d = k_q + KW'(1);
            end
            if (latch_en_c) begin
                root_d  = q_q;
                rem_d   = r_fix_c[HW:0];
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            k_q     <= k_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign root         = root_q;
    assign remainder    = rem_q;
    assign result_valid = valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sqrt_datapath.sv
// ---------------------------------------------------------------------------
// tb_sqrt_datapath
//   Directed test of sqrt_datapath (WIDTH=16) against hand-computed roots and
//   remainders, plus flag timing, OP_READY handling, abort and reset cases.
// ---------------------------------------------------------------------------
module tb_sqrt_datapath;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned HW    = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] radicand;
    logic             counter_EN;
    logic             OP_EN;
    logic             OP_READY;
    logic             COUNTER_FLAG;
    logic             MUX_FLAG;
    logic             ADDR_OR_REST_FLAG;
    logic             MUX_FLAG2;
    logic [HW-1:0]    root;
    logic [HW:0]      remainder;
    logic             result_valid;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;

    sqrt_datapath #(.WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .radicand          (radicand),
        .counter_EN        (counter_EN),
        .OP_EN             (OP_EN),
        .OP_READY          (OP_READY),
        .COUNTER_FLAG      (COUNTER_FLAG),
        .MUX_FLAG          (MUX_FLAG),
        .ADDR_OR_REST_FLAG (ADDR_OR_REST_FLAG),
        .MUX_FLAG2         (MUX_FLAG2),
        .root              (root),
        .remainder         (remainder),
        .result_valid      (result_valid),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [WIDTH-1:0] x);
        start    = 1'b1;
        radicand = x;
        tick();
        start    = 1'b0;
    endtask

    task automatic do_steps(input int n);
        counter_EN = 1'b1;
        OP_EN      = 1'b1;
        repeat (n) tick();
        counter_EN = 1'b0;
        OP_EN      = 1'b0;
    endtask

    // Full computation with flag timing and done-pulse checks
    task automatic run_vec(input logic [WIDTH-1:0] x, input int exp_root, input int exp_rem);
        do_start(x);
        check("valid_after_start", 32'(result_valid), 32'd0);
        do_steps(HW - 1);
        check("cflag_before_last", 32'(COUNTER_FLAG), 32'd0);
        do_steps(1);
        check("cflag_after_last", 32'(COUNTER_FLAG), 32'd1);
        OP_READY = 1'b1;
        tick();
        OP_READY = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("valid_set", 32'(result_valid), 32'd1);
        check("root", 32'(root), 32'(exp_root));
        check("remainder", 32'(remainder), 32'(exp_rem));
        tick();
        check("done_clear", 32'(done), 32'd0);
    endtask

    // radicand, root, remainder
    int vec_x   [20] = '{144, 65535, 0, 2, 1, 3, 4, 15, 16, 255,
                         256, 1000, 65025, 65024, 12345, 40000, 32768, 50, 200, 99};
    int vec_rt  [20] = '{12, 255, 0, 1, 1, 1, 2, 3, 4, 15,
                         16, 31, 255, 254, 111, 200, 181, 7, 14, 9};
    int vec_rem [20] = '{0, 510, 0, 1, 0, 2, 0, 6, 0, 30,
                         0, 39, 0, 508, 24, 0, 7, 1, 4, 18};

    int done_cnt;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        radicand   = '0;
        counter_EN = 1'b0;
        OP_EN      = 1'b0;
        OP_READY   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_root", 32'(root), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mux", 32'(MUX_FLAG), 32'd0);
        check("rst_addr", 32'(ADDR_OR_REST_FLAG), 32'd1);
        check("rst_cflag", 32'(COUNTER_FLAG), 32'd0);
        check("rst_mux2", 32'(MUX_FLAG2), 32'd0);
        rst = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            run_vec(vec_x[i][WIDTH-1:0], vec_rt[i], vec_rem[i]);
        end

        // 144: first step leaves R=-1, final R=-25 needs correction
        do_start(16'd144);
        do_steps(1);
        check("mux_after_step1", 32'(MUX_FLAG), 32'd1);
        check("addr_after_step1", 32'(ADDR_OR_REST_FLAG), 32'd0);
        check("mux2_before_end", 32'(MUX_FLAG2), 32'd0);
        do_steps(HW - 1);
        check("mux2_144", 32'(MUX_FLAG2), 32'd1);
        // Extra steps after completion are ignored
        do_steps(3);
        check("cflag_hold", 32'(COUNTER_FLAG), 32'd1);
        check("mux2_hold", 32'(MUX_FLAG2), 32'd1);
        // OP_READY held three cycles latches once
        done_cnt = 0;
        OP_READY = 1'b1;
        repeat (3) begin
            tick();
            if (done) done_cnt++;
        end
        OP_READY = 1'b0;
        tick();
        if (done) done_cnt++;
        check("done_once", 32'(done_cnt), 32'd1);
        check("root_144", 32'(root), 32'd12);
        check("rem_144", 32'(remainder), 32'd0);

        // 2: final remainder positive, no correction flagged
        do_start(16'd2);
        check("start_clears_valid", 32'(result_valid), 32'd0);
        check("start_keeps_root", 32'(root), 32'd12);
        do_steps(HW);
        check("mux2_2", 32'(MUX_FLAG2), 32'd0);
        check("addr_2", 32'(ADDR_OR_REST_FLAG), 32'd1);
        OP_READY = 1'b1;
        tick();
        OP_READY = 1'b0;
        check("root_2", 32'(root), 32'd1);
        check("rem_2", 32'(remainder), 32'd1);

        // OP_READY before completion is ignored
        do_start(16'd50);
        OP_READY = 1'b1;
        tick();
        tick();
        OP_READY = 1'b0;
        check("early_ready_valid", 32'(result_valid), 32'd0);
        check("early_ready_done", 32'(done), 32'd0);
        check("early_ready_root", 32'(root), 32'd1);

        // 99 with enables dropped on alternate cycles
        do_start(16'd99);
        for (int i = 0; i < 15; i++) begin
            counter_EN = ((i % 2) == 0) || ((i % 4) == 1);
            OP_EN      = ((i % 2) == 0) || ((i % 4) == 3);
            tick();
            if (i == 13) check("alt_cflag_7", 32'(COUNTER_FLAG), 32'd0);
        end
        counter_EN = 1'b0;
        OP_EN      = 1'b0;
        check("alt_cflag_8", 32'(COUNTER_FLAG), 32'd1);
        OP_READY = 1'b1;
        tick();
        OP_READY = 1'b0;
        check("alt_root", 32'(root), 32'd9);
        check("alt_rem", 32'(remainder), 32'd18);

        // Abort: restart mid-computation with a new radicand
        do_start(16'd65535);
        do_steps(5);
        run_vec(16'd144, 12, 0);

        // Reset mid-computation of 200
        do_start(16'd200);
        do_steps(4);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_root", 32'(root), 32'd0);
        check("midrst_rem", 32'(remainder), 32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_mux", 32'(MUX_FLAG), 32'd0);
        check("midrst_addr", 32'(ADDR_OR_REST_FLAG), 32'd1);
        check("midrst_cflag", 32'(COUNTER_FLAG), 32'd0);
        tick();
        rst = 1'b1;
        done_cnt = 0;
        OP_READY = 1'b1;
        repeat (4) begin
            tick();
            if (done) done_cnt++;
        end
        OP_READY = 1'b0;
        check("no_done_after_rst", 32'(done_cnt), 32'd0);
        run_vec(16'd200, 14, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
